// File: rtl/seq_pkg.sv
// seq_pkg: shared types and helpers for the serial_bit_source front end of seq_circuit.
//   src_state_t        : serializer FSM state (IDLE, SHIFT)
//   IDLE_LEVEL_DEFAULT : default level driven on x outside a frame
//   even_parity()      : XOR reduction of a data word (zero-extend narrower words)
package seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } src_state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// bit_counter: frame bit position counter.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset, count -> 0
//   clear in  synchronous clear to 0 (has priority over inc)
//   inc   in  advance the count by one
//   last  out count == FLEN-1 (last bit of the frame)
module bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FLEN  = WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LastCnt = CW'(FLEN - 1);

  logic [CW-1:0] r_count;

  // Width leaves headroom past FLEN-1, so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign last = (r_count == LastCnt);

endmodule

// File: rtl/serial_bit_source.sv
// serial_bit_source: serializes parallel words onto the single-bit x stream of seq_circuit.
// Optional feature macro: SERIAL_BIT_SOURCE_PARITY_EN appends an even-parity bit per frame.
// Ports:
//   clk       in  system clock
//   reset     in  asynchronous active-high reset
//   din       in  parallel word (WIDTH bits), sampled only on accept
//   din_valid in  din is valid
//   din_ready out block can accept din (IDLE, or the last-bit cycle of a frame)
//   x         out serial bit (IDLE_LEVEL outside a frame)
//   x_valid   out x carries a frame bit
//   busy      out frame in progress
//   done      out pulse with the last bit of a frame
module serial_bit_source
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  localparam int unsigned FLEN = WIDTH + 1;
`else
  localparam int unsigned FLEN = WIDTH;
`endif

  src_state_t      r_state;
  src_state_t      w_state_next;
  logic [FLEN-1:0] r_shift;
  logic [FLEN-1:0] w_shift_next;
  logic [FLEN-1:0] w_load;
  logic            w_last;
  logic            w_accept;
  logic            w_head;

  assign w_accept = din_valid & din_ready;

  // Frame image as loaded; the parity bit sits where it is shifted out last.
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  logic w_parity;
  assign w_parity = even_parity(32'(din));
  assign w_load   = MSB_FIRST ? {din, w_parity} : {w_parity, din};
`else
  assign w_load = din;
`endif

  assign w_head = MSB_FIRST ? r_shift[FLEN-1] : r_shift[0];

  bit_counter #(
    .WIDTH (WIDTH),
    .FLEN  (FLEN)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (w_accept),
    .inc   ((r_state == SHIFT) && !w_accept),
    .last  (w_last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = SHIFT;
      SHIFT:   if (w_last && !w_accept) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs come straight from registered state, so x/x_valid/done stay aligned.
  always_comb begin
    x_valid   = (r_state == SHIFT);
    busy      = (r_state == SHIFT);
    done      = (r_state == SHIFT) && w_last;
    x         = (r_state == SHIFT) ? w_head : IDLE_LEVEL;
    din_ready = !reset && ((r_state == IDLE) || ((r_state == SHIFT) && w_last));
  end

  // Shift register: reload on accept, otherwise advance one bit per SHIFT cycle.
  always_comb begin
    w_shift_next = r_shift;
    if (w_accept) begin
      w_shift_next = w_load;
    end else if (r_state == SHIFT) begin
      w_shift_next = MSB_FIRST ? {r_shift[FLEN-2:0], 1'b0} : {1'b0, r_shift[FLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
    end else begin
      r_shift <= w_shift_next;
    end
  end

endmodule
